uart_tx_arbiter: RTL and testbench

Shares the single on-chip UART transmitter between two byte producers: the CPU memory-mapped store path (UART TX data at 0x80000008) and a hardware debug/trace source. Each requester gets a small FIFO. A round-robin arbiter drains both FIFOs into one output register that drives the UART's `data_in`/`data_in_valid`/`data_in_ready` handshake. The block sits between the memory-mapped IO decode and the `uart` instance, replacing the direct combinational valid strobe.

---
 rtl/uart_tx_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester byte FIFOs with round-robin feed into the shared UART transmitter
//
// Ports:
//   clk, rst                        : single clock, synchronous active-high reset
//   cpu_data, cpu_valid, cpu_ready  : CPU store-path byte push (ready is combinational from full and rst)
//   dbg_data, dbg_valid, dbg_ready  : debug/trace byte push (ready is combinational from full and rst)
//   tx_data, tx_valid, tx_ready     : registered byte handshake towards the UART data_in port
//   tx_src                          : origin of the byte in tx_data, 0 = CPU, 1 = debug
//   cpu_count, dbg_count            : FIFO occupancy, 0..FIFO_DEPTH
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    cpu_data,
    input  logic                          cpu_valid,
    output logic                          cpu_ready,
    input  logic [7:0]                    dbg_data,
    input  logic                          dbg_valid,
    output logic                          dbg_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          tx_src,
    output logic [$clog2(FIFO_DEPTH):0]   cpu_count,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // CPU FIFO storage and pointers
    logic [7:0]    cpu_mem_q [FIFO_DEPTH];
    logic [7:0]    cpu_mem_d [FIFO_DEPTH];
    logic [PW-1:0] cpu_wr_ptr_q, cpu_wr_ptr_d;
    logic [PW-1:0] cpu_rd_ptr_q, cpu_rd_ptr_d;
    logic [CW-1:0] cpu_count_q,  cpu_count_d;

    // Debug FIFO storage and pointers
    logic [7:0]    dbg_mem_q [FIFO_DEPTH];
    logic [7:0]    dbg_mem_d [FIFO_DEPTH];
    logic [PW-1:0] dbg_wr_ptr_q, dbg_wr_ptr_d;
    logic [PW-1:0] dbg_rd_ptr_q, dbg_rd_ptr_d;
    logic [CW-1:0] dbg_count_q,  dbg_count_d;

    // Output stage
    state_t        state_q,      state_d;
    logic [7:0]    tx_data_q,    tx_data_d;
    logic          tx_valid_q,   tx_valid_d;
    logic          tx_src_q,     tx_src_d;
    logic          last_grant_q, last_grant_d;

    logic cpu_full;
    logic dbg_full;
    logic cpu_push;
    logic dbg_push;
    logic cpu_nonempty;
    logic dbg_nonempty;
    logic load;
    logic cpu_pop;
    logic dbg_pop;

    // Readiness looks only at the registered full flag, so a pop in the
    // same cycle never lets a push into a full FIFO.
    assign cpu_full     = (cpu_count_q == FULL_COUNT);
    assign dbg_full     = (dbg_count_q == FULL_COUNT);
    assign cpu_ready    = !cpu_full && !rst;
    assign dbg_ready    = !dbg_full && !rst;
    assign cpu_push     = cpu_valid && cpu_ready;
    assign dbg_push     = dbg_valid && dbg_ready;
    assign cpu_nonempty = (cpu_count_q != '0);
    assign dbg_nonempty = (dbg_count_q != '0);

    // The output register may take a new byte when it is empty or when the
    // byte it holds is being accepted at this same edge (no bubble).
    assign load = (state_q == ST_EMPTY) || (tx_valid_q && tx_ready);

    // last_grant_q == 1 means debug won last time, so the CPU is preferred
    // when both FIFOs have data.
    assign cpu_pop = load && cpu_nonempty && (!dbg_nonempty || last_grant_q);
    assign dbg_pop = load && dbg_nonempty && (!cpu_nonempty || !last_grant_q);

    always_comb begin
        cpu_mem_d    = cpu_mem_q;
        cpu_wr_ptr_d = cpu_wr_ptr_q;
        cpu_rd_ptr_d = cpu_rd_ptr_q;
        dbg_mem_d    = dbg_mem_q;
        dbg_wr_ptr_d = dbg_wr_ptr_q;
        dbg_rd_ptr_d = dbg_rd_ptr_q;

        if (cpu_push) begin
            cpu_mem_d[cpu_wr_ptr_q] = cpu_data;
            cpu_wr_ptr_d            = cpu_wr_ptr_q + PW'(1);
        end
        if (cpu_pop) begin
            cpu_rd_ptr_d = cpu_rd_ptr_q + PW'(1);
        end

        if (dbg_push) begin
            dbg_mem_d[dbg_wr_ptr_q] = dbg_data;
            dbg_wr_ptr_d            = dbg_wr_ptr_q + PW'(1);
        end
        if (dbg_pop) begin
            dbg_rd_ptr_d = dbg_rd_ptr_q + PW'(1);
        end

        // Push and pop together cancel out in the occupancy.
        cpu_count_d = cpu_count_q + {{(CW-1){1'b0}}, cpu_push}
                                  - {{(CW-1){1'b0}}, cpu_pop};
        dbg_count_d = dbg_count_q + {{(CW-1){1'b0}}, dbg_push}
                                  - {{(CW-1){1'b0}}, dbg_pop};
    end

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_src_d     = tx_src_q;
        last_grant_d = last_grant_q;

        if (load) begin
            if (cpu_pop) begin
                tx_data_d    = cpu_mem_q[cpu_rd_ptr_q];
                tx_src_d     = 1'b0;
                last_grant_d = 1'b0;
                state_d      = ST_HOLD;
            end else if (dbg_pop) begin
                tx_data_d    = dbg_mem_q[dbg_rd_ptr_q];
                tx_src_d     = 1'b1;
                last_grant_d = 1'b1;
                state_d      = ST_HOLD;
            end else begin
                // Nothing queued: drop valid but keep the last byte and source visible.
                state_d = ST_EMPTY;
            end
        end

        tx_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                cpu_mem_q[i] <= '0;
                dbg_mem_q[i] <= '0;
            end
            cpu_wr_ptr_q <= '0;
            cpu_rd_ptr_q <= '0;
            cpu_count_q  <= '0;
            dbg_wr_ptr_q <= '0;
            dbg_rd_ptr_q <= '0;
            dbg_count_q  <= '0;
            state_q      <= ST_EMPTY;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            tx_src_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            cpu_mem_q    <= cpu_mem_d;
            cpu_wr_ptr_q <= cpu_wr_ptr_d;
            cpu_rd_ptr_q <= cpu_rd_ptr_d;
            cpu_count_q  <= cpu_count_d;
            dbg_mem_q    <= dbg_mem_d;
            dbg_wr_ptr_q <= dbg_wr_ptr_d;
            dbg_rd_ptr_q <= dbg_rd_ptr_d;
            dbg_count_q  <= dbg_count_d;
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_src_q     <= tx_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign tx_src    = tx_src_q;
    assign cpu_count = cpu_count_q;
    assign dbg_count = dbg_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized and directed scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] cpu_data;
    logic       cpu_valid;
    logic       cpu_ready;
    logic [7:0] dbg_data;
    logic       dbg_valid;
    logic       dbg_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_src;
    logic [2:0] cpu_count;
    logic [2:0] dbg_count;

    uart_tx_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_data  (cpu_data),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .dbg_data  (dbg_data),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_src    (tx_src),
        .cpu_count (cpu_count),
        .dbg_count (dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: two byte queues, one held byte and the round-robin memory.
    logic [7:0] mcpu [$];
    logic [7:0] mdbg [$];
    logic [8:0] exp_q [$];
    logic [8:0] got_q [$];
    logic       mvalid;
    logic [7:0] mdata;
    logic       msrc;
    logic       mlast;

    initial begin
        logic acc_c, acc_d, take;
        mvalid = 1'b0;
        mdata  = 8'h00;
        msrc   = 1'b0;
        mlast  = 1'b1;
        forever begin
            @(posedge clk);
            if (rst) begin
                mcpu.delete();
                mdbg.delete();
                exp_q.delete();
                mvalid = 1'b0;
                mdata  = 8'h00;
                msrc   = 1'b0;
                mlast  = 1'b1;
            end else begin
                acc_c = cpu_valid && (mcpu.size() < DEPTH);
                acc_d = dbg_valid && (mdbg.size() < DEPTH);
                take  = !mvalid || tx_ready;
                if (take) begin
                    if (mcpu.size() > 0 && (mdbg.size() == 0 || mlast)) begin
                        mdata  = mcpu.pop_front();
                        msrc   = 1'b0;
                        mlast  = 1'b0;
                        mvalid = 1'b1;
                        exp_q.push_back({msrc, mdata});
                    end else if (mdbg.size() > 0) begin
                        mdata  = mdbg.pop_front();
                        msrc   = 1'b1;
                        mlast  = 1'b1;
                        mvalid = 1'b1;
                        exp_q.push_back({msrc, mdata});
                    end else begin
                        mvalid = 1'b0;
                    end
                end
                if (acc_c) mcpu.push_back(cpu_data);
                if (acc_d) mdbg.push_back(dbg_data);
            end
        end
    end

    // Monitor: compares the visible state every cycle and scores each handshake.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            chk("tx_valid",  tx_valid,  mvalid);
            chk("tx_data",   tx_data,   mdata);
            chk("tx_src",    tx_src,    msrc);
            chk("cpu_count", cpu_count, mcpu.size());
            chk("dbg_count", dbg_count, mdbg.size());
            chk("cpu_ready", cpu_ready, (!rst && mcpu.size() < DEPTH));
            chk("dbg_ready", dbg_ready, (!rst && mdbg.size() < DEPTH));
            if (!rst && tx_valid && tx_ready) begin
                got_q.push_back({tx_src, tx_data});
                if (exp_q.size() == 0) begin
                    chk("handshake_unexpected", {tx_src, tx_data}, 9'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("handshake_byte", {tx_src, tx_data}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        tx_ready = 1'b1;
        while ((tx_valid || cpu_count != 0 || dbg_count != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) timeout_fail(name);
    endtask

    logic [7:0] t2_exp [4] = '{8'h10, 8'h20, 8'h11, 8'h21};
    logic [7:0] t3_exp [5] = '{8'h55, 8'h60, 8'h61, 8'h62, 8'h63};

    initial begin
        logic       rdy, rdy_d, vld;
        logic [7:0] d;
        int         idx, cyc;

        rst = 1'b1; cpu_valid = 1'b0; dbg_valid = 1'b0;
        cpu_data = 8'h00; dbg_data = 8'h00; tx_ready = 1'b0;

        // 1: reset, then a single CPU byte
        step(); step();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_src", tx_src, 0);
        chk("rst_cpu_count", cpu_count, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_cpu_ready", cpu_ready, 1);
        chk("post_rst_dbg_ready", dbg_ready, 1);
        tx_ready = 1'b1; cpu_valid = 1'b1; cpu_data = 8'h41;
        step();
        cpu_valid = 1'b0;
        chk("t1_count_after_push", cpu_count, 1);
        chk("t1_valid_before_load", tx_valid, 0);
        step();
        chk("t1_valid", tx_valid, 1);
        chk("t1_data", tx_data, 8'h41);
        chk("t1_src", tx_src, 0);
        step();
        chk("t1_valid_done", tx_valid, 0);
        chk("t1_count_done", cpu_count, 0);

        // 2: contention from a fresh reset
        rst = 1'b1; step(); rst = 1'b0;
        cpu_valid = 1'b1; dbg_valid = 1'b1; cpu_data = 8'h10; dbg_data = 8'h20;
        step();
        cpu_data = 8'h11; dbg_data = 8'h21;
        step();
        cpu_valid = 1'b0; dbg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_valid", tx_valid, 1);
            chk("t2_data", tx_data, t2_exp[i]);
            chk("t2_src", tx_src, i % 2);
            step();
        end
        chk("t2_idle", tx_valid, 0);

        // 3: backpressure with the CPU producer pushing continuously
        tx_ready = 1'b0; cpu_valid = 1'b1; cpu_data = 8'h55;
        step();
        d = 8'h60; cpu_data = d;
        for (int i = 0; i < 10; i++) begin
            rdy = cpu_ready;
            step();
            chk("t3_hold_data", tx_data, 8'h55);
            if (rdy) begin
                d = d + 8'h01;
                cpu_data = d;
            end
        end
        chk("t3_count_full", cpu_count, 4);
        chk("t3_ready_low", cpu_ready, 0);
        cpu_valid = 1'b0;
        got_q.delete();
        wait_idle(50, "t3_drain");
        chk("t3_n_sent", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("t3_order", got_q[i], {1'b0, t3_exp[i]});

        // 4: wrap-around of the debug FIFO with random backpressure
        got_q.delete();
        idx = 0; cyc = 0;
        dbg_valid = 1'b1; dbg_data = 8'h00;
        while ((idx < 11 || tx_valid || dbg_count != 0) && cyc < 400) begin
            tx_ready = 1'($urandom_range(0, 1));
            rdy = dbg_ready; vld = dbg_valid;
            step();
            cyc++;
            if (vld && rdy) begin
                idx++;
                if (idx < 11) dbg_data = 8'(idx);
                else dbg_valid = 1'b0;
            end
        end
        if (cyc >= 400) timeout_fail("t4_drain");
        chk("t4_dbg_count", dbg_count, 0);
        chk("t4_n_sent", got_q.size(), 11);
        for (int i = 0; i < 11 && i < got_q.size(); i++) chk("t4_order", got_q[i], {1'b1, 8'(i)});

        // 5: full FIFO with a push offered while a pop happens
        got_q.delete();
        tx_ready = 1'b0; cpu_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_data = 8'(8'hA0 + i);
            step();
        end
        chk("t5_count_full", cpu_count, 4);
        cpu_data = 8'hEE; tx_ready = 1'b1;
        #1;
        chk("t5_ready_full", cpu_ready, 0);
        step();
        cpu_valid = 1'b0;
        chk("t5_count_after", cpu_count, 3);
        chk("t5_ready_after", cpu_ready, 1);
        chk("t5_next_byte", tx_data, 8'hA1);
        wait_idle(50, "t5_drain");
        chk("t5_n_sent", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("t5_order", got_q[i], {1'b0, 8'(8'hA0 + i)});

        // 6: reset while holding a byte with bytes queued
        tx_ready = 1'b0; cpu_valid = 1'b1; cpu_data = 8'h7E;
        step();
        cpu_data = 8'h01; dbg_valid = 1'b1; dbg_data = 8'h03;
        step();
        dbg_valid = 1'b0; cpu_data = 8'h02;
        step();
        cpu_valid = 1'b0;
        chk("t6_hold_data", tx_data, 8'h7E);
        chk("t6_queued", cpu_count + dbg_count, 3);
        rst = 1'b1; tx_ready = 1'b1;
        cpu_valid = 1'b1; cpu_data = 8'h99; dbg_valid = 1'b1; dbg_data = 8'h98;
        step();
        rst = 1'b0; cpu_valid = 1'b0; dbg_valid = 1'b0;
        chk("t6_valid", tx_valid, 0);
        chk("t6_cpu_count", cpu_count, 0);
        chk("t6_dbg_count", dbg_count, 0);
        chk("t6_data", tx_data, 8'h00);
        cpu_valid = 1'b1; dbg_valid = 1'b1; cpu_data = 8'hC1; dbg_data = 8'hD1;
        step();
        cpu_valid = 1'b0; dbg_valid = 1'b0;
        step();
        chk("t6_grant_src", tx_src, 0);
        chk("t6_grant_data", tx_data, 8'hC1);
        wait_idle(50, "t6_drain");

        // 7: random mixed traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            rdy = cpu_ready; rdy_d = dbg_ready;
            step();
            if (!cpu_valid || rdy) begin
                cpu_valid = 1'($urandom_range(0, 1));
                cpu_data  = 8'($urandom);
            end
            if (!dbg_valid || rdy_d) begin
                dbg_valid = 1'($urandom_range(0, 1));
                dbg_data  = 8'($urandom);
            end
        end
        rst = 1'b0; cpu_valid = 1'b0; dbg_valid = 1'b0;
        wait_idle(50, "t7_drain");
        step();
        chk("final_exp_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
